// File: rtl/timer_counter.sv
// Memory-mapped countdown timer: CTRL/PRESET/COUNT word registers on the device bus,
// a four-state count FSM, and a maskable interrupt line.
module timer_counter #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Addr,
    input  logic        We,
    input  logic [31:0] WD,
    output logic [31:0] RD,
    output logic        IRQ
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CNT  = 2'd2,
        S_INT  = 2'd3
    } state_t;

    localparam logic [31:0] LAST_ADDR = BASE_ADDR + 32'h0000_000B;

    state_t      state_q, state_d;
    logic [3:0]  ctrl_q, ctrl_d;
    logic [31:0] preset_q, preset_d;
    logic [31:0] count_q, count_d;
    logic        irq_pending_q, irq_pending_d;

    logic        sel;
    logic [1:0]  idx;
    logic        wr_ctrl;
    logic        wr_preset;
    logic        enable;
    logic        auto_reload;

    // The window is 16-byte aligned, so the low address bits index the register.
    assign sel         = (Addr >= BASE_ADDR) && (Addr <= LAST_ADDR);
    assign idx         = Addr[3:2];
    assign wr_ctrl     = sel && We && (idx == 2'd0);
    assign wr_preset   = sel && We && (idx == 2'd1);
    assign enable      = ctrl_q[0];
    assign auto_reload = (ctrl_q[2:1] == 2'b01);

    always_comb begin
        RD = 32'd0;
        if (sel) begin
            case (idx)
                2'd0:    RD = {28'd0, ctrl_q};
                2'd1:    RD = preset_q;
                2'd2:    RD = count_q;
                default: RD = 32'd0;
            endcase
        end
    end

    always_comb begin
        state_d       = state_q;
        ctrl_d        = ctrl_q;
        preset_d      = preset_q;
        count_d       = count_q;
        irq_pending_d = irq_pending_q;

        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                count_d = preset_q;
                state_d = S_CNT;
            end
            S_CNT: begin
                if (!enable) begin
                    state_d = S_IDLE;
                end else if (count_q > 32'd1) begin
                    count_d = count_q - 32'd1;
                end else begin
                    // A loaded value of 0 expires on the same cycle as 1.
                    count_d       = 32'd0;
                    irq_pending_d = 1'b1;
                    state_d       = S_INT;
                end
            end
            S_INT: begin
                if (auto_reload) begin
                    irq_pending_d = 1'b0;
                    state_d       = S_LOAD;
                end else begin
                    ctrl_d[0] = 1'b0;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Bus writes come last so they win over the FSM's own Enable clear.
        if (wr_ctrl) begin
            ctrl_d        = WD[3:0];
            irq_pending_d = 1'b0;
        end
        if (wr_preset) begin
            preset_d      = WD;
            irq_pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            ctrl_q        <= 4'd0;
            preset_q      <= 32'd0;
            count_q       <= 32'd0;
            irq_pending_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ctrl_q        <= ctrl_d;
            preset_q      <= preset_d;
            count_q       <= count_d;
            irq_pending_q <= irq_pending_d;
        end
    end

    assign IRQ = irq_pending_q & ctrl_q[3];

endmodule

// File: tb/tb_timer_counter.sv
// Scoreboard bench for timer_counter: a timeline-based reference model predicts RD/IRQ
// for each bus transaction; a negedge monitor pops and compares.
module tb_timer_counter;

    localparam logic [31:0] BASE = 32'h0000_7F00;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Addr;
    logic        We;
    logic [31:0] WD;
    logic [31:0] RD;
    logic        IRQ;

    always #5 clk = ~clk;

    timer_counter #(.BASE_ADDR(BASE)) dut (
        .clk   (clk),
        .reset (reset),
        .Addr  (Addr),
        .We    (We),
        .WD    (WD),
        .RD    (RD),
        .IRQ   (IRQ)
    );

    typedef struct {
        int          id;
        logic [31:0] addr;
        logic        we;
        logic [31:0] rd;
        logic        irq;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_txn    = 0;

    // Reference model: register contents plus a timeline. A run starts at edge m_s
    // (the edge that leaves idle); COUNT is loaded at edge m_s+1 and expires at
    // edge m_s+1+m_n, with m_n = max(PRESET,1).
    logic [3:0]  m_ctrl;
    logic [31:0] m_preset;
    logic [31:0] m_count;
    bit          m_irq;
    bit          m_idle;
    int          m_s;
    int          m_n;
    int          m_cyc;

    function automatic void model_reset();
        m_ctrl   = 4'd0;
        m_preset = 32'd0;
        m_count  = 32'd0;
        m_irq    = 1'b0;
        m_idle   = 1'b1;
        m_s      = 0;
        m_n      = 1;
    endfunction

    function automatic bit in_window(logic [31:0] a);
        return (a >= BASE) && (a <= BASE + 32'd11);
    endfunction

    function automatic logic [31:0] model_read(logic [31:0] a);
        logic [31:0] off;
        if (!in_window(a)) return 32'd0;
        off = a - BASE;
        case (off / 4)
            0:       return {28'd0, m_ctrl};
            1:       return m_preset;
            2:       return m_count;
            default: return 32'd0;
        endcase
    endfunction

    function automatic void model_edge(bit we, logic [31:0] a, logic [31:0] wd);
        int          c;
        int          rem;
        logic [3:0]  nctrl;
        logic [31:0] npreset;
        logic [31:0] ncount;
        bit          nirq;
        bit          nidle;
        int          ns;
        c       = m_cyc + 1;
        nctrl   = m_ctrl;
        npreset = m_preset;
        ncount  = m_count;
        nirq    = m_irq;
        nidle   = m_idle;
        ns      = m_s;
        if (m_idle) begin
            if (m_ctrl[0]) begin
                nidle = 1'b0;
                ns    = c;
            end
        end else if (c == m_s + 1) begin
            ncount = m_preset;
            m_n    = (m_preset == 32'd0) ? 1 : int'(m_preset);
        end else if (c - 1 <= m_s + m_n) begin
            if (!m_ctrl[0]) begin
                nidle = 1'b1;
            end else begin
                rem    = m_n - (c - m_s - 1);
                ncount = (rem > 0) ? 32'(rem) : 32'd0;
                if (c == m_s + 1 + m_n) nirq = 1'b1;
            end
        end else begin
            if (m_ctrl[2:1] == 2'b01) begin
                nirq = 1'b0;
                ns   = c;
            end else begin
                nctrl[0] = 1'b0;
                nidle    = 1'b1;
            end
        end
        if (we && in_window(a)) begin
            if ((a - BASE) / 4 == 0) begin
                nctrl = wd[3:0];
                nirq  = 1'b0;
            end else if ((a - BASE) / 4 == 1) begin
                npreset = wd;
                nirq    = 1'b0;
            end
        end
        m_ctrl   = nctrl;
        m_preset = npreset;
        m_count  = ncount;
        m_irq    = nirq;
        m_idle   = nidle;
        m_s      = ns;
        m_cyc    = c;
    endfunction

    task automatic do_txn(bit rst_n, bit we, logic [31:0] a, logic [31:0] wd);
        exp_t e;
        @(posedge clk);
        #1;
        reset = rst_n;
        We    = we;
        Addr  = a;
        WD    = wd;
        if (!rst_n) model_reset();
        e.id   = n_txn;
        e.addr = a;
        e.we   = we;
        e.rd   = model_read(a);
        e.irq  = m_irq & m_ctrl[3];
        sb.push_back(e);
        n_txn++;
        if (rst_n) model_edge(we, a, wd);
        else m_cyc++;
    endtask

    task automatic wr(logic [31:0] a, logic [31:0] d);
        do_txn(1'b1, 1'b1, a, d);
    endtask

    task automatic rd_cycles(int n);
        for (int i = 0; i < n; i++) do_txn(1'b1, 1'b0, BASE + 32'(4 * (i % 3)), 32'd0);
    endtask

    task automatic rd_count(int n);
        for (int i = 0; i < n; i++) do_txn(1'b1, 1'b0, BASE + 32'd8, 32'd0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_checks++;
                if (RD !== e.rd) begin
                    n_fail++;
                    $display("FAIL rd txn=%0d addr=%h actual=%h required=%h", e.id, e.addr, RD, e.rd);
                end
                n_checks++;
                if (IRQ !== e.irq) begin
                    n_fail++;
                    $display("FAIL irq txn=%0d addr=%h actual=%b required=%b", e.id, e.addr, IRQ, e.irq);
                end
                $display("txn %0d addr=%h we=%b rd=%h irq=%b", e.id, e.addr, e.we, RD, IRQ);
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int          r;
        int          k;
        logic [31:0] a;
        logic [31:0] d;
        bit          rst_n;
        bit          we;
        reset = 1'b0;
        We    = 1'b0;
        Addr  = 32'd0;
        WD    = 32'd0;
        m_cyc = 0;
        model_reset();

        do_txn(1'b0, 1'b0, BASE, 32'd0);
        do_txn(1'b1, 1'b0, BASE + 32'd8, 32'd0);

        // One-shot with IM, then a CTRL write clears the interrupt.
        wr(BASE + 32'd4, 32'd5);
        wr(BASE, 32'h9);
        rd_count(9);
        rd_cycles(3);
        wr(BASE, 32'h8);
        rd_cycles(3);

        // Auto-reload pulses.
        wr(BASE + 32'd4, 32'd3);
        wr(BASE, 32'hB);
        rd_count(16);
        wr(BASE, 32'h0);

        // Masked one-shot.
        wr(BASE + 32'd4, 32'd4);
        wr(BASE, 32'h1);
        rd_cycles(12);

        // Disable mid-count freezes COUNT; re-enable reloads.
        wr(BASE + 32'd4, 32'd10);
        wr(BASE, 32'h1);
        rd_count(5);
        wr(BASE, 32'h0);
        rd_count(4);
        wr(BASE, 32'h1);
        rd_count(4);

        // Writes outside CTRL/PRESET are ignored.
        wr(BASE + 32'hC, 32'hFFFF);
        wr(BASE + 32'h8, 32'hFFFF);
        do_txn(1'b1, 1'b0, BASE + 32'hC, 32'd0);
        rd_cycles(3);

        // Reset mid-count.
        wr(BASE, 32'h9);
        rd_count(3);
        do_txn(1'b0, 1'b0, BASE + 32'd8, 32'd0);
        rd_cycles(6);

        // PRESET = 0 behaves like 1.
        wr(BASE + 32'd4, 32'd0);
        wr(BASE, 32'hB);
        rd_count(8);

        for (int i = 0; i < 700; i++) begin
            r     = $urandom_range(0, 99);
            rst_n = (r != 0);
            we    = (r >= 1) && (r <= 8);
            k     = $urandom_range(0, 9);
            case (k)
                0, 1, 2: a = BASE;
                3, 4:    a = BASE + 32'd4;
                5, 6:    a = BASE + 32'd8;
                7:       a = BASE + 32'hC;
                8:       a = BASE - 32'd4;
                default: a = BASE + 32'h10;
            endcase
            if (k == 3 || k == 4) begin
                d = 32'($urandom_range(0, 12));
            end else begin
                d    = $urandom();
                d[0] = ($urandom_range(0, 3) != 0);
            end
            do_txn(rst_n, we, a, d);
        end

        @(posedge clk);
        #1;
        We = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
